// File: rtl/vga_write_arbiter_if.sv
// Requester-side beat bus plus the registered framebuffer write port of the arbiter.
interface vga_write_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) ();
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_last;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   fb_write;
  logic [ADDR_W-1:0]      fb_addr;
  logic [DATA_W-1:0]      fb_data;

  // master: the pixel producers (and framebuffer observer)
  modport master (
    output req_valid, req_last, req_addr, req_data,
    input  req_ready, fb_write, fb_addr, fb_data
  );

  // slave: the arbiter
  modport slave (
    input  req_valid, req_last, req_addr, req_data,
    output req_ready, fb_write, fb_addr, fb_data
  );
endinterface

// File: rtl/vga_write_arbiter.sv
// Round-robin burst arbiter onto the framebuffer write port; grant 1 cycle, fb_write 2 cycles after valid, one beat/cycle.
// Ungranted requesters see ready=0 and hold their beat; VBLANK_GATE_EN makes ready follow vblank inside a burst.
module vga_write_arbiter #(
  parameter int NREQ      = 3,
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                clock,
  input  logic                reset,
  vga_write_arbiter_if.slave  bus,
  input  logic                vblank,
  output logic [2:0]          grant_id,
  output logic                busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nxt;
  logic [2:0]          rr_ptr;
  logic [CNT_W-1:0]    beat_cnt;

  logic                found;
  logic [2:0]          pick;
  logic [3:0]          sum;
  logic [2*NREQ-1:0]   dbl;

  logic                gate;
  logic                vld_g;
  logic                last_g;
  logic [ADDR_W-1:0]   addr_g;
  logic [DATA_W-1:0]   data_g;
  logic                accept;
  logic                stall;
  logic                cnt_done;
  logic                burst_end;

`ifdef VBLANK_GATE_EN
  assign gate = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate = 1'b1;
`endif

  // Rotate valids so bit 0 is rr_ptr; the first set bit is the winner.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    sum   = '0;
    dbl   = {bus.req_valid, bus.req_valid} >> rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + 4'(i);
        if (sum >= 4'(NREQ))
          sum = sum - 4'(NREQ);
        pick  = sum[2:0];
      end
    end
  end

  always_comb begin
    vld_g  = 1'b0;
    last_g = 1'b0;
    addr_g = '0;
    data_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == 3'(i)) begin
        vld_g  = bus.req_valid[i];
        last_g = bus.req_last[i];
        addr_g = bus.req_addr[i*ADDR_W +: ADDR_W];
        data_g = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A gated (vblank=0) cycle is neither an acceptance nor a stall.
  assign accept    = (state == BURST) && gate && vld_g;
  assign stall     = (state == BURST) && gate && !vld_g;
  assign cnt_done  = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign burst_end = stall || (accept && (last_g || cnt_done));

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)     state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state == BURST);
    bus.req_ready = '0;
    if (state == BURST && gate)
      bus.req_ready = NREQ'(1) << grant_id;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      beat_cnt     <= '0;
      bus.fb_write <= 1'b0;
      bus.fb_addr  <= '0;
      bus.fb_data  <= '0;
    end else begin
      bus.fb_write <= accept;
      if (accept) begin
        bus.fb_addr <= addr_g;
        bus.fb_data <= data_g;
        beat_cnt    <= beat_cnt + 1'b1;
      end
      if (state == IDLE && found) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end
      if (burst_end)
        rr_ptr <= (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
    end
  end

endmodule

// File: doc/vga_write_arbiter.md
# vga_write_arbiter

Round-robin arbiter and burst sequencer sharing the single framebuffer write port of the VGA component among several pixel producers: the Avalon host path, the puck sprite engine and the paddle sprite engines. Each requester presents address/data beats with a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst and drives registered write strobes into the framebuffer write port.

## Interface
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 17, framebuffer word address width
- DATA_W, 16, pixel word width
- MAX_BURST, 16, maximum beats per grant (1..256)

- clock  in  1  system/data clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester beat valid
- req_last  in  NREQ  beat is the last of the requester's burst
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed data; same packing as req_addr
- req_ready  out  NREQ  beat accepted when valid & ready on the same edge
- vblank  in  1  high during vertical blanking; synchronous to clock
- fb_write  out  1  one-cycle write strobe to the framebuffer
- fb_addr  out  ADDR_W  write address; valid while fb_write=1
- fb_data  out  DATA_W  write data; valid while fb_write=1
- grant_id  out  3  index of the current or last granted requester
- busy  out  1  high while in state BURST

## Operation
- States: IDLE, BURST.
- IDLE:
  - All req_ready low.
  - If any req_valid is set, select the first requester at or after rr_ptr (wrapping modulo NREQ) with valid=1.
  - Latch that requester into grant_id, clear beat_cnt, go to BURST.
- BURST:
  - req_ready[grant_id] = 1; all others 0. This is gated in VBLANK mode; see Configuration.
  - A beat is accepted when req_valid[g] & req_ready[g]. On acceptance, register fb_addr/fb_data from slice g and set fb_write=1 for one cycle; beat_cnt increments.
  - The burst ends on the accepting edge when:
    - req_last[g]=1, or
    - beat_cnt reaches MAX_BURST-1 before incrementing (i.e. MAX_BURST beats done).
  - The burst also ends on any edge where req_ready[g]=1 but req_valid[g]=0 (requester stalled). No beat is written in that case.
  - On burst end: rr_ptr = (g+1) mod NREQ, next state IDLE.
- Every burst is followed by at least one IDLE cycle. No back-to-back grants.
- fb_write is 0 in every cycle not following an accepted beat.
- Requesters not granted see ready=0 and must hold their beat; the arbiter never drops or duplicates a beat.
- grant_id holds its last value in IDLE.
- beat_cnt is log2(MAX_BURST)+1 bits; it saturates only via burst termination and never wraps.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - fb_write=0, fb_addr=0, fb_data=0.
  - busy=0, req_ready=0.
- Reset mid-burst returns to IDLE on that edge. fb_write is 0 in the following cycle, and the beat presented at the reset edge is not accepted.
- Latency from req_valid rising in IDLE (sampled at edge k) to acceptance:
  - grant at edge k
  - first acceptance at edge k+1
  - fb_write visible after edge k+1, i.e. 2 cycles.
- Throughput inside a burst: one beat per cycle.
- Simultaneous requests in IDLE: the lowest index at or after rr_ptr wins. The winner rotates to lowest priority after its burst.
- req_last together with beat MAX_BURST: single termination, rr_ptr advances once.

## Configuration
- VBLANK_GATE_EN defined:
  - In BURST, req_ready[g] = vblank.
  - A vblank=0 cycle is neither an acceptance nor a stall; the grant is held, beat_cnt is unchanged and the burst resumes when vblank returns.
  - IDLE arbitration is unaffected.
- VBLANK_GATE_EN undefined: vblank is ignored and req_ready[g]=1 throughout BURST.

## Test plan
- Reset then a single requester:
  - Stimulus: req 1 sends beats addr 0x00010/0x00011/0x00012 (last on third), data 0xF800/0x07E0/0x001F.
  - Response: fb_write high for 3 consecutive cycles with matching addr/data, first strobe 2 cycles after valid; rr_ptr=2 afterward; busy low for one cycle.
- All three requesters valid continuously with 2-beat bursts:
  - Response: grant order 0,1,2,0,… with exactly one IDLE cycle between bursts; no beat lost or duplicated across 12 beats.
- Requester 0 streams 40 beats, never asserting last, with MAX_BURST=16:
  - Response: grant released after 16 beats; requester 1 (valid) granted next; requester 0 resumes at beat 17.
- Stall then reset:
  - Granted requester drops valid after 2 beats: burst ends that edge, no fb_write, rr_ptr advances.
  - Separately, reset asserted on a beat-accept edge mid-burst: fb_write=0 the next cycle, state IDLE, rr_ptr=0.
- With VBLANK_GATE_EN, vblank low for 5 cycles mid-burst:
  - Response: req_ready low and no fb_write for 5 cycles; grant_id unchanged; remaining beats written once vblank=1.
  - Without the macro the same stimulus produces uninterrupted writes.
